// File: rtl/kb_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send,
// shifts one byte + odd parity + stop on device clock falling edges, then
// samples the device ACK. Pulses o_done on ACK, o_err on NACK or timeout.
// Ports:
//   i_clk, i_rst_n       system clock, async active-low reset
//   i_start, i_tx_data   one-cycle send request and byte (accepted in IDLE only)
//   i_sclk, i_data       PS/2 clock/data pad read-back (asynchronous)
//   o_sclk_oe, o_data_oe open-drain pull-low enables
//   o_busy               transaction in progress
//   o_done, o_err        single-cycle completion / failure pulses
module kb_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [7:0] i_tx_data,
  input  logic       i_sclk,
  input  logic       i_data,
  output logic       o_sclk_oe,
  output logic       o_data_oe,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err
);

  localparam int unsigned MAX_CYC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                       : TIMEOUT_CYCLES;
  localparam int unsigned CW = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INHIBIT = 3'd1,
    RTS     = 3'd2,
    SHIFT   = 3'd3,
    ACK     = 3'd4
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d, cnt_inc;
  logic [3:0]    bit_cnt, bit_cnt_d;
  logic [7:0]    tx, tx_d;
  logic          par, par_d;
  logic          data_oe_d, sclk_oe_d, busy_d, done_d, err_d;

  // Two-flop synchronizers plus a history flop for edge detection; idle level is 1.
  logic sclk_meta, sclk_sync, sclk_prev;
  logic data_meta, data_sync;
  logic fall;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sclk_meta <= 1'b1;
      sclk_sync <= 1'b1;
      sclk_prev <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      sclk_meta <= i_sclk;
      sclk_sync <= sclk_meta;
      sclk_prev <= sclk_sync;
      data_meta <= i_data;
      data_sync <= data_meta;
    end
  end

  assign fall    = sclk_prev & ~sclk_sync;
  assign cnt_inc = cnt + CW'(1);

  // State, datapath and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      tx        <= '0;
      par       <= 1'b0;
      o_sclk_oe <= 1'b0;
      o_data_oe <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      bit_cnt   <= bit_cnt_d;
      tx        <= tx_d;
      par       <= par_d;
      o_sclk_oe <= sclk_oe_d;
      o_data_oe <= data_oe_d;
      o_busy    <= busy_d;
      o_done    <= done_d;
      o_err     <= err_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    bit_cnt_d = bit_cnt;
    tx_d      = tx;
    par_d     = par;
    data_oe_d = o_data_oe;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state)
      IDLE: begin
        data_oe_d = 1'b0;
        // A start coinciding with the terminating pulse belongs to the old transaction.
        if (i_start && !o_done && !o_err) begin
          tx_d      = i_tx_data;
          par_d     = ~^i_tx_data;
          cnt_d     = '0;
          bit_cnt_d = '0;
          state_d   = INHIBIT;
        end
      end
      INHIBIT: begin
        cnt_d = cnt_inc;
        if (cnt == CW'(INHIBIT_CYCLES - 1)) begin
          cnt_d     = '0;
          data_oe_d = 1'b1;
          state_d   = RTS;
        end
      end
      RTS: begin
        cnt_d     = '0;
        data_oe_d = 1'b1;
        state_d   = SHIFT;
      end
      SHIFT: begin
        cnt_d = cnt_inc;
        // Timeout wins over a falling edge in the same cycle.
        if (cnt_inc == CW'(TIMEOUT_CYCLES)) begin
          data_oe_d = 1'b0;
          err_d     = 1'b1;
          state_d   = IDLE;
        end else if (fall) begin
          bit_cnt_d = bit_cnt + 4'd1;
          if (bit_cnt < 4'd8) begin
            data_oe_d = ~tx[bit_cnt[2:0]];
          end else if (bit_cnt == 4'd8) begin
            data_oe_d = ~par;
          end else begin
            data_oe_d = 1'b0;
            state_d   = ACK;
          end
        end
      end
      ACK: begin
        cnt_d = cnt_inc;
        if (cnt_inc == CW'(TIMEOUT_CYCLES)) begin
          data_oe_d = 1'b0;
          err_d     = 1'b1;
          state_d   = IDLE;
        end else if (fall) begin
          bit_cnt_d = bit_cnt + 4'd1;
          done_d    = ~data_sync;
          err_d     = data_sync;
          state_d   = IDLE;
        end
      end
      default: begin
        data_oe_d = 1'b0;
        state_d   = IDLE;
      end
    endcase

    sclk_oe_d = (state_d == INHIBIT) || (state_d == RTS);
    busy_d    = (state_d != IDLE);
  end

endmodule

// File: tb/tb_kb_host_tx.sv
// Self-checking bench for kb_host_tx: table of directed transactions, random
// transactions checked against a frame/parity model, and hand-written
// sequences for timeout and mid-transaction reset.
module tb_kb_host_tx;

  localparam int unsigned INH  = 8;
  localparam int unsigned TO   = 400;
  localparam int          HALF = 17;  // device clock half period (34-cycle period fits 11 edges inside TO)
  localparam int          LEAD = 10;  // device delay from clock release to first falling edge

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_start = 1'b0;
  logic [7:0] i_tx_data = 8'h00;
  logic       i_sclk = 1'b1;
  logic       i_data = 1'b1;
  logic       o_sclk_oe, o_data_oe, o_busy, o_done, o_err;

  kb_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_start   (i_start),
    .i_tx_data (i_tx_data),
    .i_sclk    (i_sclk),
    .i_data    (i_data),
    .o_sclk_oe (o_sclk_oe),
    .o_data_oe (o_data_oe),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_err     (o_err)
  );

  always #5 i_clk = ~i_clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_done, n_err, n_both;
  bit   poke_on_done = 1'b0;
  logic pulse_busy;

  typedef struct {
    logic [7:0] data;
    bit         ack;
    bit         spurious;
    bit         poke;
    bit         exp_done;
    bit         exp_err;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Expected o_data_oe after each edge: start, 8 data LSB first, odd parity, released stop.
  function automatic logic [10:0] frame_oe(input logic [7:0] b);
    logic [10:0] f;
    int ones;
    ones = 0;
    f[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      f[1+i] = ~b[i];
      if (b[i]) ones++;
    end
    f[9]  = (ones % 2 == 0) ? 1'b0 : 1'b1;  // parity bit is 1 when ones are even -> oe 0
    f[10] = 1'b0;
    return f;
  endfunction

  // One clock step, sampling at the falling edge; tallies pulses.
  task automatic tick();
    @(negedge i_clk);
    if (o_done) n_done++;
    if (o_err) n_err++;
    if (o_done && o_err) n_both++;
    if (o_done || o_err) pulse_busy = pulse_busy | o_busy;
    if (poke_on_done) i_start = o_done | o_err;
  endtask

  task automatic start_and_inhibit(input logic [7:0] b, input bit spurious, input bit poke_busy,
                                   output bit ok);
    int inh, rts;
    inh = 0;
    rts = 0;
    ok  = 1'b0;
    i_tx_data = b;
    i_start   = 1'b1;
    tick();
    i_start = 1'b0;
    for (int j = 0; j < 100; j++) begin
      if (!o_sclk_oe && o_busy) begin
        ok = 1'b1;
        break;
      end
      if (o_sclk_oe && !o_data_oe) inh++;
      else if (o_sclk_oe && o_data_oe) rts++;
      if (spurious && j < 4) i_sclk = j[0];
      if (poke_busy && j == 2) begin
        i_tx_data = ~b;
        i_start   = 1'b1;
      end
      if (poke_busy && j == 3) i_start = 1'b0;
      tick();
    end
    chk("inhibit_cycles", inh, INH);
    chk("rts_cycles", rts, 1);
    chk("shift_entry", {31'd0, ok}, 1);
  endtask

  // Device clocks n falling edges; records o_data_oe just before each edge.
  task automatic device_edges(input int n, input bit ack, output logic [10:0] got);
    got = '0;
    for (int k = 1; k <= n; k++) begin
      repeat ((k == 1) ? LEAD : HALF) tick();
      got[k-1] = o_data_oe;
      if (k == 11 && ack) i_data = 1'b0;
      i_sclk = 1'b0;
      repeat (HALF) tick();
      i_sclk = 1'b1;
    end
    i_data = 1'b1;
  endtask

  task automatic run_txn(input logic [7:0] b, input bit ack, input bit spurious, input bit poke,
                         input bit exp_done, input bit exp_err);
    bit          ok;
    logic [10:0] got;
    n_done = 0;
    n_err  = 0;
    n_both = 0;
    pulse_busy = 1'b0;
    start_and_inhibit(b, spurious, poke, ok);
    poke_on_done = poke;
    device_edges(11, ack, got);
    repeat (40) tick();
    poke_on_done = 1'b0;
    i_start = 1'b0;
    chk("frame_bits", {21'd0, got}, {21'd0, frame_oe(b)});
    chk("done_count", n_done, {31'd0, exp_done});
    chk("err_count", n_err, {31'd0, exp_err});
    chk("done_err_overlap", n_both, 0);
    chk("busy_in_pulse", {31'd0, pulse_busy}, 0);
    chk("busy_after", {31'd0, o_busy}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    int          cnt;
    logic [7:0]  b;
    bit          ack;
    logic [10:0] got;

    tbl[0] = '{8'hED, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{8'h81, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    repeat (3) @(negedge i_clk);
    chk("reset_outputs", {27'd0, o_sclk_oe, o_data_oe, o_busy, o_done, o_err}, 0);
    i_rst_n = 1'b1;
    repeat (3) tick();

    foreach (tbl[i])
      run_txn(tbl[i].data, tbl[i].ack, tbl[i].spurious, tbl[i].poke, tbl[i].exp_done, tbl[i].exp_err);

    for (int r = 0; r < 8; r++) begin
      b   = 8'($urandom);
      ack = 1'($urandom_range(0, 1));
      run_txn(b, ack, 1'b0, 1'b0, ack, ~ack);
    end

    // Device never clocks: error exactly TO cycles after SHIFT entry.
    n_err = 0;
    start_and_inhibit(8'h5A, 1'b0, 1'b0, ok);
    cnt = 0;
    while (!o_err && cnt < 1000) begin
      tick();
      cnt++;
    end
    chk("timeout_cycles", cnt, TO);
    chk("timeout_lines", {28'd0, o_sclk_oe, o_data_oe, o_busy, o_done}, 0);
    chk("timeout_err_count", n_err, 1);
    tick();
    chk("timeout_err_single", {31'd0, o_err}, 0);
    repeat (5) tick();

    // Reset after the fifth falling edge of a 0xFF send.
    start_and_inhibit(8'hFF, 1'b0, 1'b0, ok);
    device_edges(5, 1'b0, got);
    chk("pre_reset_busy", {31'd0, o_busy}, 1);
    #2 i_rst_n = 1'b0;
    #1 chk("reset_async", {29'd0, o_sclk_oe, o_data_oe, o_busy}, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    n_done = 0;
    n_err  = 0;
    repeat (500) tick();
    chk("post_reset_pulses", n_done + n_err, 0);
    chk("post_reset_busy", {31'd0, o_busy}, 0);
    run_txn(8'hF4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
